controle_jogo: RTL and testbench
================================

Name: controle_jogo

Overview:
- Blackjack game controller; sits directly downstream of the scoring block (`pontuacao`) and drives its requests.
- Sequences the initial deal, player hit/stay turn, dealer auto-draw and final comparison.
- Issues one-card requests to the scoring block via `pjogador`/`pdealer` and consumes `pts_jogador`/`pts_dealer`/`cartaok`.
- Produces the game result for display logic.

Parameters:
- LIMITE_DEALER, 17, dealer keeps drawing while pts_dealer < this value.
- BLACKJACK, 21, target score; above this is bust.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inicia  in  1  start/new-game request, synchronous single-cycle pulse.
- hit  in  1  player asks for a card, synchronous single-cycle pulse.
- stay  in  1  player stands, synchronous single-cycle pulse.
- cartaok  in  1  scoring block has finished the current card.
- pts_jogador  in  6  player score from scoring block.
- pts_dealer  in  6  dealer score from scoring block.
- pjogador  out  1  request card for player.
- pdealer  out  1  request card for dealer.
- limpa  out  1  one-cycle pulse at game start, used to clear the scoring block.
- vitoria  out  1  player wins.
- derrota  out  1  player loses.
- empate  out  1  tie.
- fim_jogo  out  1  result valid.
- estado  out  4  current state code, for display/debug.

Behaviour:
- Reset: reset=0 asynchronously forces state OCIOSO and all outputs to 0. Reset mid-request drops pjogador/pdealer immediately.
- Card handshake, identical for every card:
  - Assert exactly one of pjogador/pdealer from the cycle after entering a request state.
  - Hold it until cartaok=1 is sampled, then deassert both.
  - Wait until cartaok=0 is sampled before any new request.
  - Scores are read in the cycle cartaok=1 is sampled; they are stable then.
  - pjogador and pdealer are never both 1.
- States, with estado codes:
  - 0 OCIOSO: wait for inicia.
  - 1 LIMPA: limpa=1 for one cycle; result outputs cleared.
  - 2 DJ1, 3 DD1, 4 DJ2, 5 DD2: initial deal, in the order player, dealer, player, dealer. Each state runs one full handshake.
  - 6 VEZ_JOG: wait for hit/stay.
  - 7 COMPRA_J: one player card.
  - 8 VEZ_DEALER: evaluate dealer score.
  - 9 COMPRA_D: one dealer card.
  - 10 COMPARA: decide the result.
  - 11 FIM: hold the result.
- Transitions:
  - OCIOSO→LIMPA on inicia.
  - LIMPA→DJ1.
  - Each deal state advances after its handshake completes (cartaok back to 0). DD2→VEZ_JOG.
  - VEZ_JOG:
    - stay→VEZ_DEALER.
    - hit→COMPRA_J.
    - hit and stay in the same cycle: stay wins.
    - inicia is ignored outside OCIOSO/FIM.
  - COMPRA_J done:
    - pts_jogador > BLACKJACK → FIM with derrota=1; dealer does not draw.
    - pts_jogador == BLACKJACK → VEZ_DEALER (auto-stay).
    - Otherwise → VEZ_JOG.
  - VEZ_DEALER: pts_dealer < LIMITE_DEALER → COMPRA_D, else → COMPARA.
  - COMPRA_D done → VEZ_DEALER.
  - COMPARA, evaluated in this order:
    - pts_dealer > BLACKJACK → vitoria.
    - pts_jogador > pts_dealer → vitoria.
    - Equal → empate.
    - Otherwise → derrota.
    - Then → FIM.
  - FIM: fim_jogo=1; exactly one of vitoria/derrota/empate is 1. Hold until inicia, then FIM→LIMPA.
- Arithmetic: all comparisons are 6-bit unsigned. The scorer never exceeds 31, so no wrap handling is required.
- Registered outputs; estado mirrors the state register.

Optional Feature:
- Macro: BLACKJACK_NATURAL_EN.
- Defined: at DD2 handshake completion, special cases apply:
  - pts_jogador == 21 and pts_dealer != 21 → FIM with vitoria=1, skipping player and dealer turns.
  - Both equal 21 → FIM with empate=1.
- Not defined: DD2 always → VEZ_JOG; a 21 is resolved only through the normal flow.

Test Plan:
- Reset while pjogador=1 in DJ1 → pjogador drops to 0 asynchronously; estado=0; all results 0.
- inicia, then scorer model with cartaok latency 6 cycles → limpa pulses once; requests issued in order J,D,J,D; each request held until cartaok=1; no request issued while cartaok=1.
- Player 12, hit gives 25 → derrota=1, fim_jogo=1; pdealer never asserted after DD2.
- Player stays at 18, dealer 12 then draws to 16 then 20 → dealer draws exactly twice; derrota=1.
- Player 19 stay, dealer 17 → no dealer draw; vitoria=1. Repeat with dealer 19 → empate=1. Repeat with dealer drawing to 23 → vitoria=1.
- hit and stay asserted in the same cycle in VEZ_JOG → VEZ_DEALER entered, no player card. With BLACKJACK_NATURAL_EN, player 21 / dealer 10 after deal → FIM, vitoria=1, estado=11.

Source files
------------

// File: rtl/controle_jogo.sv
// Blackjack game controller: deal, player turn, dealer auto-draw and final comparison.
// Optional macro BLACKJACK_NATURAL_EN resolves a natural 21 right after the initial deal.
module controle_jogo #(
  parameter int LIMITE_DEALER = 17,
  parameter int BLACKJACK     = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inicia,
  input  logic       hit,
  input  logic       stay,
  input  logic       cartaok,
  input  logic [5:0] pts_jogador,
  input  logic [5:0] pts_dealer,
  output logic       pjogador,
  output logic       pdealer,
  output logic       limpa,
  output logic       vitoria,
  output logic       derrota,
  output logic       empate,
  output logic       fim_jogo,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    OCIOSO     = 4'd0,
    LIMPA      = 4'd1,
    DJ1        = 4'd2,
    DD1        = 4'd3,
    DJ2        = 4'd4,
    DD2        = 4'd5,
    VEZ_JOG    = 4'd6,
    COMPRA_J   = 4'd7,
    VEZ_DEALER = 4'd8,
    COMPRA_D   = 4'd9,
    COMPARA    = 4'd10,
    FIM        = 4'd11
  } estado_t;

  localparam logic [5:0] LIM = 6'(LIMITE_DEALER);
  localparam logic [5:0] BJ  = 6'(BLACKJACK);

  estado_t    state_q, state_d;
  logic       aguarda_q, aguarda_d;
  logic       pj_q, pj_d, pd_q, pd_d;
  logic       limpa_q, limpa_d;
  logic       vit_q, vit_d, der_q, der_d, emp_q, emp_d, fim_q, fim_d;
  logic [5:0] ptsj_q, ptsj_d, ptsd_q, ptsd_d;
  logic       pedido_j, pedido_d, card_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= OCIOSO;
      aguarda_q <= 1'b0;
      pj_q      <= 1'b0;
      pd_q      <= 1'b0;
      limpa_q   <= 1'b0;
      vit_q     <= 1'b0;
      der_q     <= 1'b0;
      emp_q     <= 1'b0;
      fim_q     <= 1'b0;
      ptsj_q    <= 6'd0;
      ptsd_q    <= 6'd0;
    end else begin
      state_q   <= state_d;
      aguarda_q <= aguarda_d;
      pj_q      <= pj_d;
      pd_q      <= pd_d;
      limpa_q   <= limpa_d;
      vit_q     <= vit_d;
      der_q     <= der_d;
      emp_q     <= emp_d;
      fim_q     <= fim_d;
      ptsj_q    <= ptsj_d;
      ptsd_q    <= ptsd_d;
    end
  end

  // Card handshake (valid/ready style): the request is raised only while
  // cartaok=0, held until cartaok=1 is sampled (scores captured then), and the
  // state advances only once cartaok has returned to 0.
  always_comb begin
    state_d   = state_q;
    aguarda_d = aguarda_q;
    pj_d      = pj_q;
    pd_d      = pd_q;
    vit_d     = vit_q;
    der_d     = der_q;
    emp_d     = emp_q;
    ptsj_d    = ptsj_q;
    ptsd_d    = ptsd_q;
    card_done = 1'b0;
    pedido_j  = (state_q == DJ1) || (state_q == DJ2) || (state_q == COMPRA_J);
    pedido_d  = (state_q == DD1) || (state_q == DD2) || (state_q == COMPRA_D);

    if (pedido_j || pedido_d) begin
      if (!aguarda_q) begin
        if ((pj_q || pd_q) && cartaok) begin
          pj_d      = 1'b0;
          pd_d      = 1'b0;
          aguarda_d = 1'b1;
          ptsj_d    = pts_jogador;
          ptsd_d    = pts_dealer;
        end else if (!(pj_q || pd_q) && !cartaok) begin
          pj_d = pedido_j;
          pd_d = pedido_d;
        end
      end else if (!cartaok) begin
        aguarda_d = 1'b0;
        card_done = 1'b1;
      end
    end

    case (state_q)
      OCIOSO:     if (inicia) state_d = LIMPA;
      LIMPA:      state_d = DJ1;
      DJ1:        if (card_done) state_d = DD1;
      DD1:        if (card_done) state_d = DJ2;
      DJ2:        if (card_done) state_d = DD2;
      DD2: begin
        if (card_done) begin
          state_d = VEZ_JOG;
`ifdef BLACKJACK_NATURAL_EN
          if (ptsj_q == BJ && ptsd_q == BJ) begin
            state_d = FIM;
            emp_d   = 1'b1;
          end else if (ptsj_q == BJ) begin
            state_d = FIM;
            vit_d   = 1'b1;
          end
`endif
        end
      end
      VEZ_JOG: begin
        if (stay)     state_d = VEZ_DEALER;
        else if (hit) state_d = COMPRA_J;
      end
      COMPRA_J: begin
        if (card_done) begin
          if (ptsj_q > BJ) begin
            state_d = FIM;
            der_d   = 1'b1;
          end else if (ptsj_q == BJ) begin
            state_d = VEZ_DEALER;
          end else begin
            state_d = VEZ_JOG;
          end
        end
      end
      VEZ_DEALER: state_d = (ptsd_q < LIM) ? COMPRA_D : COMPARA;
      COMPRA_D:   if (card_done) state_d = VEZ_DEALER;
      COMPARA: begin
        state_d = FIM;
        if (ptsd_q > BJ)          vit_d = 1'b1;
        else if (ptsj_q > ptsd_q) vit_d = 1'b1;
        else if (ptsj_q == ptsd_q) emp_d = 1'b1;
        else                      der_d = 1'b1;
      end
      FIM:        if (inicia) state_d = LIMPA;
      default:    state_d = OCIOSO;
    endcase

    if (state_d == LIMPA) begin
      vit_d = 1'b0;
      der_d = 1'b0;
      emp_d = 1'b0;
    end
    limpa_d = (state_d == LIMPA);
    fim_d   = (state_d == FIM);
  end

  assign pjogador = pj_q;
  assign pdealer  = pd_q;
  assign limpa    = limpa_q;
  assign vitoria  = vit_q;
  assign derrota  = der_q;
  assign empate   = emp_q;
  assign fim_jogo = fim_q;
  assign estado   = state_q;

endmodule

// File: tb/tb_controle_jogo.sv
// Directed bench for controle_jogo with a scorer model answering card requests
// after a fixed latency; expectations are hand-computed game outcomes.
module tb_controle_jogo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       inicia = 1'b0, hit = 1'b0, stay = 1'b0, cartaok = 1'b0;
  logic [5:0] pts_jogador = 6'd0, pts_dealer = 6'd0;
  logic       pjogador, pdealer, limpa, vitoria, derrota, empate, fim_jogo;
  logic [3:0] estado;
  int         total = 0;
  int         bad = 0;
  int         both_hi = 0;

  controle_jogo dut (
    .clock(clock), .reset(reset), .inicia(inicia), .hit(hit), .stay(stay),
    .cartaok(cartaok), .pts_jogador(pts_jogador), .pts_dealer(pts_dealer),
    .pjogador(pjogador), .pdealer(pdealer), .limpa(limpa), .vitoria(vitoria),
    .derrota(derrota), .empate(empate), .fim_jogo(fim_jogo), .estado(estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (pjogador && pdealer) both_hi++;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int which);
    if (which == 0) inicia = 1'b1;
    if (which == 1) hit = 1'b1;
    if (which == 2) stay = 1'b1;
    if (which == 3) begin hit = 1'b1; stay = 1'b1; end
    @(negedge clock);
    inicia = 1'b0; hit = 1'b0; stay = 1'b0;
  endtask

  task automatic start_game(input string tag);
    pts_jogador = 6'd0;
    pts_dealer  = 6'd0;
    pulse(0);
    chk({tag, "_limpa_on"}, {limpa, estado, vitoria, derrota, empate, fim_jogo},
        {1'b1, 4'd1, 4'b0000});
    @(negedge clock);
    chk({tag, "_limpa_off"}, limpa, 0);
  endtask

  // Scorer model: answer one request with 6 cycles of latency.
  task automatic serve(input string tag, input logic is_j, input logic [5:0] score);
    int n = 0;
    int held = 1;
    while (!(pjogador || pdealer) && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_req_timeout"}, (n < 60), 1);
    chk({tag, "_req_kind"}, {pjogador, pdealer}, {is_j, !is_j});
    repeat (6) begin
      @(negedge clock);
      if (!(pjogador === is_j && pdealer === !is_j)) held = 0;
    end
    chk({tag, "_req_held"}, held, 1);
    if (is_j) pts_jogador = score;
    else      pts_dealer  = score;
    cartaok = 1'b1;
    @(negedge clock);
    chk({tag, "_req_drop"}, {pjogador, pdealer}, 0);
    @(negedge clock);
    chk({tag, "_no_req_while_ok"}, {pjogador, pdealer}, 0);
    cartaok = 1'b0;
  endtask

  task automatic deal(input string tag, input logic [5:0] j1, d1, j2, d2);
    serve({tag, "_dj1"}, 1'b1, j1);
    serve({tag, "_dd1"}, 1'b0, d1);
    serve({tag, "_dj2"}, 1'b1, j2);
    serve({tag, "_dd2"}, 1'b0, d2);
  endtask

  task automatic wait_estado(input string tag, input logic [3:0] code);
    int n = 0;
    while (estado !== code && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_estado"}, estado, code);
  endtask

  // Wait for the result; any request seen on the way is counted as unexpected.
  task automatic wait_fim(input string tag, input logic [2:0] vde);
    int n = 0;
    int reqs = 0;
    while (!fim_jogo && n < 80) begin
      if (pjogador || pdealer) reqs++;
      @(negedge clock);
      n++;
    end
    chk({tag, "_fim"}, fim_jogo, 1);
    chk({tag, "_extra_reqs"}, reqs, 0);
    chk({tag, "_result"}, {vitoria, derrota, empate, estado}, {vde, 4'd11});
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_state", {estado, pjogador, pdealer, limpa, vitoria, derrota, empate, fim_jogo}, 0);
    reset = 1'b1;
    @(negedge clock);

    // Asynchronous reset while the first player request is up.
    start_game("rst");
    wait_estado("rst_dj1", 4'd2);
    @(negedge clock);
    chk("rst_pj_up", pjogador, 1);
    #2 reset = 1'b0;
    #1 chk("rst_async", {estado, pjogador, pdealer, vitoria, derrota, empate, fim_jogo}, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Player 12 hits to 25: bust, dealer never draws.
    start_game("g1");
    deal("g1", 6'd5, 6'd6, 6'd12, 6'd10);
    wait_estado("g1_vez", 4'd6);
    pulse(0);
    chk("g1_inicia_ignored", estado, 6);
    pulse(1);
    serve("g1_hit", 1'b1, 6'd25);
    wait_fim("g1", 3'b010);

    // Stay at 18, dealer 12 -> 16 -> 20: two draws, player loses.
    start_game("g2");
    deal("g2", 6'd10, 6'd5, 6'd18, 6'd12);
    wait_estado("g2_vez", 4'd6);
    pulse(2);
    serve("g2_d1", 1'b0, 6'd16);
    serve("g2_d2", 1'b0, 6'd20);
    wait_fim("g2", 3'b010);

    // Player 19 vs dealer 17: no draw, win.
    start_game("g3");
    deal("g3", 6'd10, 6'd7, 6'd19, 6'd17);
    wait_estado("g3_vez", 4'd6);
    pulse(2);
    wait_fim("g3", 3'b100);

    // Player 19 vs dealer 19: tie.
    start_game("g4");
    deal("g4", 6'd10, 6'd9, 6'd19, 6'd19);
    wait_estado("g4_vez", 4'd6);
    pulse(2);
    wait_fim("g4", 3'b001);

    // Player 19, dealer 13 draws to 23: dealer bust, win.
    start_game("g5");
    deal("g5", 6'd10, 6'd3, 6'd19, 6'd13);
    wait_estado("g5_vez", 4'd6);
    pulse(2);
    serve("g5_d1", 1'b0, 6'd23);
    wait_fim("g5", 3'b100);

    // hit and stay together: stay wins, no player card; 15 vs 18 loses.
    start_game("g6");
    deal("g6", 6'd10, 6'd8, 6'd15, 6'd18);
    wait_estado("g6_vez", 4'd6);
    pulse(3);
    chk("g6_stay_wins", estado, 8);
    wait_fim("g6", 3'b010);

    // Hit to exactly 21 auto-stays; dealer 17 stands, player wins.
    start_game("g7");
    deal("g7", 6'd10, 6'd10, 6'd15, 6'd17);
    wait_estado("g7_vez", 4'd6);
    pulse(1);
    serve("g7_hit", 1'b1, 6'd21);
    wait_fim("g7", 3'b100);

    // Player 21 / dealer 10 after the deal.
    start_game("g8");
    deal("g8", 6'd11, 6'd5, 6'd21, 6'd10);
`ifdef BLACKJACK_NATURAL_EN
    wait_fim("g8_natural", 3'b100);
`else
    wait_estado("g8_vez", 4'd6);
    pulse(2);
    serve("g8_d1", 1'b0, 6'd20);
    wait_fim("g8", 3'b100);
`endif

    chk("never_both_requests", both_hi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
